// File: rtl/weapon_pkg.sv
// Shared codes and helpers for the CY weapon engine: image codes, CY attack codes,
// inactive stage codes, weapon types and the attack FSM encoding.
package weapon_pkg;

   localparam logic [3:0] IMG_EMPTY   = 4'hF;

   localparam logic [3:0] CY_BACK     = 4'hA;
   localparam logic [3:0] CY_FRONT    = 4'hB;
   localparam logic [3:0] CY_LEFT     = 4'hC;
   localparam logic [3:0] CY_RIGHT    = 4'hD;

   localparam logic [3:0] STAGE_INIT  = 4'h0;
   localparam logic [3:0] STAGE_OVER  = 4'hE;
   localparam logic [3:0] STAGE_WIN   = 4'hF;

   localparam logic [2:0] TYPE_WOODEN = 3'd0;
   localparam logic [2:0] TYPE_BASYS  = 3'd1;
   localparam logic [2:0] TYPE_CAR    = 3'd2;

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_COOLDOWN} fsm_e;

   // Encoding doubles as the low two bits of the image code.
   typedef enum logic [1:0] {
      DIR_FRONT = 2'd0,
      DIR_BACK  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   function automatic logic is_attack(input logic [3:0] cy);
      return cy inside {CY_BACK, CY_FRONT, CY_LEFT, CY_RIGHT};
   endfunction

   function automatic dir_e cy_dir(input logic [3:0] cy);
      case (cy)
         CY_BACK:  return DIR_BACK;
         CY_LEFT:  return DIR_LEFT;
         CY_RIGHT: return DIR_RIGHT;
         default:  return DIR_FRONT;
      endcase
   endfunction

   function automatic logic stage_active(input logic [3:0] stage);
      return !(stage inside {STAGE_INIT, STAGE_OVER, STAGE_WIN});
   endfunction

   function automatic logic [3:0] img_code(input logic [1:0] wtype, input dir_e dir);
      return {wtype, dir};
   endfunction

endpackage

// File: rtl/weapon_ctrl_if.sv
// Controller-side bus of the weapon engine. The hit input exists only when
// WEAPON_HIT_EN is defined.
interface weapon_ctrl_if #(parameter int COORD_W = 10);

   logic [2:0]         type_i;
   logic [3:0]         state_cy_i;
   logic [COORD_W-1:0] pos_h_cy_i;
   logic [COORD_W-1:0] pos_v_cy_i;
   logic [3:0]         stage_i;
`ifdef WEAPON_HIT_EN
   logic               hit_i;
`endif
   logic [3:0]         state_o;
   logic [COORD_W-1:0] pos_h_o;
   logic [COORD_W-1:0] pos_v_o;
   logic               busy_o;

   modport master (
      output type_i, state_cy_i, pos_h_cy_i, pos_v_cy_i, stage_i,
`ifdef WEAPON_HIT_EN
      output hit_i,
`endif
      input  state_o, pos_h_o, pos_v_o, busy_o
   );

   modport slave (
      input  type_i, state_cy_i, pos_h_cy_i, pos_v_cy_i, stage_i,
`ifdef WEAPON_HIT_EN
      input  hit_i,
`endif
      output state_o, pos_h_o, pos_v_o, busy_o
   );

endinterface

// File: rtl/weapon_timer.sv
// Loadable saturating down-counter shared by the swing and cooldown phases.
module weapon_timer #(parameter int W = 4) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] value_i,
   input  logic         en_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   // NOTE: async reset in the sensitivity list, and sequential state only ever takes <=.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= value_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/weapon_ctrl.sv
// Weapon engine for CY: latched attack FSM (IDLE/ACTIVE/COOLDOWN), melee swing and
// travelling car projectile. Define WEAPON_HIT_EN to let a hit report end an attack early.
module weapon_ctrl
   import weapon_pkg::*;
#(
   parameter int COORD_W      = 10,
   parameter int OFFSET       = 20,
   parameter int SWING_CYC    = 8,
   parameter int COOLDOWN_CYC = 16,
   parameter int PROJ_STEP    = 4,
   parameter int H_MAX        = 639,
   parameter int V_MAX        = 479
) (
   input  logic         clk,
   input  logic         rst,
   weapon_ctrl_if.slave bus
);

   localparam int TMR_MAX = (SWING_CYC > COOLDOWN_CYC) ? SWING_CYC : COOLDOWN_CYC;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [COORD_W-1:0] OFF    = COORD_W'(OFFSET);
   localparam logic signed [COORD_W:0] STEP_S = (COORD_W+1)'(PROJ_STEP);
   localparam logic signed [COORD_W:0] HMAX_S = (COORD_W+1)'(H_MAX);
   localparam logic signed [COORD_W:0] VMAX_S = (COORD_W+1)'(V_MAX);

   fsm_e               fsm_q;
   logic [3:0]         state_q;
   logic [COORD_W-1:0] pos_h_q, pos_v_q;
   logic               busy_q;
   logic [1:0]         type_q;
   dir_e               dir_q;

   logic               stage_act, attack_req, is_proj, hit_act, active_done;
   dir_e               cy_dir_d;
   logic signed [COORD_W:0] step_h, step_v, proj_h_d, proj_v_d;
   logic               proj_out;
   logic               tmr_load, tmr_en, tmr_zero;
   logic [TMR_W-1:0]   tmr_val;

   function automatic logic [COORD_W-1:0] off_h(input logic [COORD_W-1:0] h, input dir_e d);
      case (d)
         DIR_LEFT:  return h + OFF;
         DIR_RIGHT: return h - OFF;
         default:   return h;
      endcase
   endfunction

   function automatic logic [COORD_W-1:0] off_v(input logic [COORD_W-1:0] v, input dir_e d);
      case (d)
         DIR_BACK:  return v - OFF;
         DIR_FRONT: return v + OFF;
         default:   return v;
      endcase
   endfunction

   assign stage_act  = stage_active(bus.stage_i);
   assign attack_req = (bus.type_i <= TYPE_CAR) && is_attack(bus.state_cy_i);
   assign cy_dir_d   = cy_dir(bus.state_cy_i);
   assign is_proj    = (type_q == 2'(TYPE_CAR));

`ifdef WEAPON_HIT_EN
   assign hit_act = bus.hit_i;
`else
   assign hit_act = 1'b0;
`endif

   // Projectile bounds are checked one bit wider and signed so a step past 0 cannot wrap.
   always_comb begin
      step_h = '0;
      step_v = '0;
      case (dir_q)
         DIR_LEFT:  step_h = STEP_S;
         DIR_RIGHT: step_h = -STEP_S;
         DIR_FRONT: step_v = STEP_S;
         DIR_BACK:  step_v = -STEP_S;
         default:   ;
      endcase
      proj_h_d = $signed({1'b0, pos_h_q}) + step_h;
      proj_v_d = $signed({1'b0, pos_v_q}) + step_v;
      proj_out = (proj_h_d < 0) || (proj_h_d > HMAX_S) ||
                 (proj_v_d < 0) || (proj_v_d > VMAX_S);
   end

   assign active_done = hit_act || (is_proj ? proj_out : tmr_zero);

   // NOTE: every output of an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      tmr_val  = '0;
      if (!stage_act) begin
         tmr_load = 1'b1;
      end else begin
         case (fsm_q)
            ST_IDLE: if (attack_req) begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(SWING_CYC - 1);
            end
            ST_ACTIVE: if (active_done) begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(COOLDOWN_CYC - 1);
            end else begin
               tmr_en = 1'b1;
            end
            ST_COOLDOWN: tmr_en = 1'b1;
            default: ;
         endcase
      end
   end

   weapon_timer #(.W(TMR_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load_i  (tmr_load),
      .value_i (tmr_val),
      .en_i    (tmr_en),
      .zero_o  (tmr_zero)
   );

   // Outputs are registered with the values belonging to the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= ST_IDLE;
         state_q <= IMG_EMPTY;
         pos_h_q <= '0;
         pos_v_q <= '0;
         busy_q  <= 1'b0;
         type_q  <= '0;
         dir_q   <= DIR_FRONT;
      end else if (!stage_act) begin
         fsm_q   <= ST_IDLE;
         state_q <= IMG_EMPTY;
         pos_h_q <= bus.pos_h_cy_i;
         pos_v_q <= bus.pos_v_cy_i;
         busy_q  <= 1'b0;
      end else begin
         case (fsm_q)
            ST_IDLE: begin
               if (attack_req) begin
                  fsm_q   <= ST_ACTIVE;
                  type_q  <= bus.type_i[1:0];
                  dir_q   <= cy_dir_d;
                  state_q <= img_code(bus.type_i[1:0], cy_dir_d);
                  pos_h_q <= off_h(bus.pos_h_cy_i, cy_dir_d);
                  pos_v_q <= off_v(bus.pos_v_cy_i, cy_dir_d);
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IMG_EMPTY;
                  pos_h_q <= bus.pos_h_cy_i;
                  pos_v_q <= bus.pos_v_cy_i;
                  busy_q  <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (active_done) begin
                  fsm_q   <= ST_COOLDOWN;
                  state_q <= IMG_EMPTY;
                  pos_h_q <= bus.pos_h_cy_i;
                  pos_v_q <= bus.pos_v_cy_i;
               end else if (is_proj) begin
                  pos_h_q <= proj_h_d[COORD_W-1:0];
                  pos_v_q <= proj_v_d[COORD_W-1:0];
               end else begin
                  pos_h_q <= off_h(bus.pos_h_cy_i, dir_q);
                  pos_v_q <= off_v(bus.pos_v_cy_i, dir_q);
               end
            end
            ST_COOLDOWN: begin
               state_q <= IMG_EMPTY;
               pos_h_q <= bus.pos_h_cy_i;
               pos_v_q <= bus.pos_v_cy_i;
               if (tmr_zero) begin
                  fsm_q  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               fsm_q   <= ST_IDLE;
               state_q <= IMG_EMPTY;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.state_o = state_q;
   assign bus.pos_h_o = pos_h_q;
   assign bus.pos_v_o = pos_v_q;
   assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_weapon_ctrl.sv
// Table-driven bench for weapon_ctrl with a scoreboard queue of expected outputs;
// hand-written sequences cover the asynchronous reset and the optional hit input.
module tb_weapon_ctrl;
   import weapon_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   weapon_ctrl_if #(.COORD_W(10)) bus ();

   weapon_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string      tag;
      logic [2:0] typ;
      logic [3:0] scy;
      logic [9:0] ch, cv;
      logic [3:0] stg;
      logic       hit;
      logic [3:0] e_st;
      logic [9:0] e_h, e_v;
      logic       e_busy;
   } vec_t;

   typedef struct {
      string      tag;
      logic [3:0] st;
      logic [9:0] h, v;
      logic       busy;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string tag, input logic [2:0] typ, input logic [3:0] scy,
                               input int ch, input int cv, input logic [3:0] stg, input logic hit,
                               input logic [3:0] e_st, input int e_h, input int e_v, input logic e_busy);
      vec_t v;
      v.tag = tag;   v.typ = typ;      v.scy = scy;
      v.ch  = 10'(ch); v.cv = 10'(cv); v.stg = stg; v.hit = hit;
      v.e_st = e_st; v.e_h = 10'(e_h); v.e_v = 10'(e_v); v.e_busy = e_busy;
      return v;
   endfunction

   task automatic add(input int n, input vec_t v);
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      bus.type_i     = v.typ;
      bus.state_cy_i = v.scy;
      bus.pos_h_cy_i = v.ch;
      bus.pos_v_cy_i = v.cv;
      bus.stage_i    = v.stg;
`ifdef WEAPON_HIT_EN
      bus.hit_i      = v.hit;
`endif
   endtask

   // Called just after a falling edge; leaves the bench at the next falling edge.
   task automatic apply(input vec_t v);
      exp_t e;
      drive(v);
      e.tag = v.tag; e.st = v.e_st; e.h = v.e_h; e.v = v.e_v; e.busy = v.e_busy;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: empty queue at %s", v.tag);
      end else begin
         e = sb.pop_front();
         check({e.tag, ".state"}, 32'(bus.state_o), 32'(e.st));
         check({e.tag, ".pos_h"}, 32'(bus.pos_h_o), 32'(e.h));
         check({e.tag, ".pos_v"}, 32'(bus.pos_v_o), 32'(e.v));
         check({e.tag, ".busy"},  32'(bus.busy_o),  32'(e.busy));
      end
      @(negedge clk);
   endtask

   initial begin
      drive(mk("init", 3'd0, 4'h0, 0, 0, 4'h0, 1'b0, 4'hF, 0, 0, 1'b0));
      repeat (2) @(negedge clk);
      check("reset.state", 32'(bus.state_o), 32'hF);
      check("reset.pos_h", 32'(bus.pos_h_o), 32'd0);
      check("reset.pos_v", 32'(bus.pos_v_o), 32'd0);
      check("reset.busy",  32'(bus.busy_o),  32'd0);
      rst = 1'b0;

      // Unarmed, non-attack and inactive-stage requests never start an attack.
      add(2,  mk("idle_unarmed", 3'd5, 4'hB, 100, 100, 4'h1, 1'b0, 4'hF, 100, 100, 1'b0));
      add(1,  mk("idle_noatk",   3'd0, 4'h5, 100, 100, 4'h1, 1'b0, 4'hF, 100, 100, 1'b0));
      add(1,  mk("stage0_atk",   3'd0, 4'hB, 100, 100, 4'h0, 1'b0, 4'hF, 100, 100, 1'b0));
      // Wooden front swing: 8 ACTIVE clocks tracking CY, then 16 cooldown, then IDLE.
      add(4,  mk("melee_front",  3'd0, 4'hB, 100, 100, 4'h1, 1'b0, 4'h0, 100, 120, 1'b1));
      add(4,  mk("melee_track",  3'd1, 4'hD, 200, 50,  4'h1, 1'b0, 4'h0, 200, 70,  1'b1));
      add(16, mk("melee_cool",   3'd0, 4'h0, 200, 50,  4'h1, 1'b0, 4'hF, 200, 50,  1'b1));
      add(1,  mk("melee_idle",   3'd0, 4'h0, 200, 50,  4'h1, 1'b0, 4'hF, 200, 50,  1'b0));
      // Basys left held: level-sensitive retrigger after a single IDLE clock.
      add(8,  mk("held_left",    3'd1, 4'hC, 300, 300, 4'h1, 1'b0, 4'h6, 320, 300, 1'b1));
      add(16, mk("held_cool",    3'd1, 4'hC, 300, 300, 4'h1, 1'b0, 4'hF, 300, 300, 1'b1));
      add(1,  mk("held_idle",    3'd1, 4'hC, 300, 300, 4'h1, 1'b0, 4'hF, 300, 300, 1'b0));
      add(2,  mk("held_retrig",  3'd1, 4'hC, 300, 300, 4'h1, 1'b0, 4'h6, 320, 300, 1'b1));
      add(1,  mk("stage_zero",   3'd1, 4'hC, 300, 300, 4'h0, 1'b0, 4'hF, 300, 300, 1'b0));
      add(3,  mk("unarmed_held", 3'd5, 4'hC, 300, 300, 4'h1, 1'b0, 4'hF, 300, 300, 1'b0));
      // Car right: launch at CY-20, moves 4/clk ignoring CY, stops before going below 0.
      add(1,  mk("proj_launch",  3'd2, 4'hD, 30,  200, 4'h1, 1'b0, 4'hB, 10,  200, 1'b1));
      add(1,  mk("proj_move1",   3'd2, 4'hD, 500, 400, 4'h1, 1'b0, 4'hB, 6,   200, 1'b1));
      add(1,  mk("proj_move2",   3'd2, 4'hD, 500, 400, 4'h1, 1'b0, 4'hB, 2,   200, 1'b1));
      add(1,  mk("proj_edge",    3'd2, 4'hD, 500, 400, 4'h1, 1'b0, 4'hF, 500, 400, 1'b1));
      add(15, mk("proj_cool",    3'd2, 4'h0, 500, 400, 4'h1, 1'b0, 4'hF, 500, 400, 1'b1));
      add(1,  mk("proj_idle",    3'd2, 4'h0, 500, 400, 4'h1, 1'b0, 4'hF, 500, 400, 1'b0));
      // Car left lands exactly on H_MAX, then the next step would leave the screen.
      for (int k = 0; k < 6; k++)
         add(1, mk("proj_hmax", 3'd2, 4'hC, 599, 100, 4'h1, 1'b0, 4'hA, 619 + 4 * k, 100, 1'b1));
      add(1,  mk("proj_hmax_end", 3'd2, 4'hC, 599, 100, 4'h1, 1'b0, 4'hF, 599, 100, 1'b1));
      add(1,  mk("proj_hmax_clr", 3'd2, 4'hC, 599, 100, 4'h0, 1'b0, 4'hF, 599, 100, 1'b0));
      // Game over during a swing aborts it on the next clock.
      add(2,  mk("stage_e_act",  3'd1, 4'hA, 50,  60,  4'h1, 1'b0, 4'h5, 50,  40,  1'b1));
      add(1,  mk("stage_e",      3'd1, 4'hA, 50,  60,  4'hE, 1'b0, 4'hF, 50,  60,  1'b0));
      add(1,  mk("stage_e_idle", 3'd1, 4'h0, 50,  60,  4'h1, 1'b0, 4'hF, 50,  60,  1'b0));
      // Melee offset wraps modulo 2^COORD_W.
      add(1,  mk("wrap_back",    3'd0, 4'hA, 5,   10,  4'h1, 1'b0, 4'h1, 5,   1014, 1'b1));
      add(1,  mk("wrap_win",     3'd0, 4'hA, 5,   10,  4'hF, 1'b0, 4'hF, 5,   10,  1'b0));
`ifdef WEAPON_HIT_EN
      add(1,  mk("hit_launch",   3'd2, 4'hB, 100, 100, 4'h1, 1'b0, 4'h8, 100, 120, 1'b1));
      add(1,  mk("hit_move1",    3'd2, 4'hB, 100, 100, 4'h1, 1'b0, 4'h8, 100, 124, 1'b1));
      add(1,  mk("hit_move2",    3'd2, 4'hB, 100, 100, 4'h1, 1'b0, 4'h8, 100, 128, 1'b1));
      add(1,  mk("hit_pulse",    3'd2, 4'hB, 100, 100, 4'h1, 1'b1, 4'hF, 100, 100, 1'b1));
      add(1,  mk("hit_cool",     3'd2, 4'h0, 100, 100, 4'h1, 1'b0, 4'hF, 100, 100, 1'b1));
      add(1,  mk("hit_clear",    3'd2, 4'h0, 100, 100, 4'h0, 1'b0, 4'hF, 100, 100, 1'b0));
`endif

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

      // Asynchronous reset in the middle of a swing clears outputs without a clock edge.
      repeat (3) apply(mk("rst_pre", 3'd0, 4'hB, 100, 100, 4'h1, 1'b0, 4'h0, 100, 120, 1'b1));
      #2 rst = 1'b1;
      #1;
      check("rst_async.state", 32'(bus.state_o), 32'hF);
      check("rst_async.pos_h", 32'(bus.pos_h_o), 32'd0);
      check("rst_async.pos_v", 32'(bus.pos_v_o), 32'd0);
      check("rst_async.busy",  32'(bus.busy_o),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      apply(mk("rst_post", 3'd0, 4'h0, 100, 100, 4'h1, 1'b0, 4'hF, 100, 100, 1'b0));
      apply(mk("rst_retrig", 3'd0, 4'hB, 100, 100, 4'h1, 1'b0, 4'h0, 100, 120, 1'b1));

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: %0d entries left", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
